alu_muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the RV32 datapath's shared 32-bit ALU.
- Accepts one MUL/DIVU/REMU request at a time over a valid/ready handshake.
- Drives the ALU operand and control lines each step, consumes the ALU result, and returns a held result over a second valid/ready handshake.
- Sits beside the datapath ALU. When the sequencer is not IDLE, the ALU operand muxes select the sequencer's outputs.

---
 rtl/alu_muldiv_pkg.sv | 30 +++
 rtl/alu_muldiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL_STEP,
        DIV_CMP,
        DIV_SUB,
        RESP
    } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiply / restoring divide sequencer that borrows the datapath ALU.
// Latency: MUL 33 (fewer with ALU_MULDIV_EARLY_EXIT_EN), DIVU/REMU 65, div-by-zero/reserved 1.
// Backpressure: one op in flight; the result is held in RESP until rsp_ready, req_ready only in IDLE.
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [XLEN-1:0] alu_srca,
    output logic [XLEN-1:0] alu_srcb,
    output logic [2:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    state_e          state;
    op_e             op;
    logic [XLEN-1:0] opa, opb;
    logic [XLEN-1:0] acc, mcand, mplier;
    logic [XLEN-1:0] rem, quo, s_q;
    logic            msb_q, lt_q;
    logic [CW-1:0]   cnt;

    logic [XLEN-1:0] s_now, acc_nxt, mplier_nxt, quo_nxt, rem_nxt;
    logic            take, mul_done;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Next-value helpers: shifted partial remainder, conditional accumulate, restore decision.
    // msb_q marks a 33-bit partial remainder, which always exceeds the divisor.
    always_comb begin
        s_now      = {rem[XLEN-2:0], quo[XLEN-1]};
        acc_nxt    = mplier[0] ? alu_result : acc;
        mplier_nxt = mplier >> 1;
        take       = msb_q | ~lt_q;
        quo_nxt    = {quo[XLEN-1:1], take};
        rem_nxt    = take ? alu_result : s_q;
`ifdef ALU_MULDIV_EARLY_EXIT_EN
        mul_done   = (cnt == CNT_LAST) || (mplier_nxt == '0);
`else
        mul_done   = (cnt == CNT_LAST);
`endif
    end

    // ALU operand/control mux; parked at add(0,0) whenever no step is issued.
    always_comb begin
        alu_srca    = '0;
        alu_srcb    = '0;
        alu_control = ALU_ADD;
        case (state)
            MUL_STEP: begin
                alu_srca    = acc;
                alu_srcb    = mcand;
                alu_control = ALU_ADD;
            end
            DIV_CMP: begin
                alu_srca    = s_now;
                alu_srcb    = opb;
                alu_control = ALU_SLTU;
            end
            DIV_SUB: begin
                alu_srca    = s_q;
                alu_srcb    = opb;
                alu_control = ALU_SUB;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with its operand shift registers and the held response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op        <= OP_MUL;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            s_q       <= '0;
            msb_q     <= 1'b0;
            lt_q      <= 1'b0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op    <= op_e'(req_op);
                        opa   <= req_a;
                        opb   <= req_b;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (op == OP_RSVD) begin
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (op != OP_MUL && opb == '0) begin
                        rsp_data  <= (op == OP_DIVU) ? '1 : opa;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef ALU_MULDIV_EARLY_EXIT_EN
                    end else if (opb == '0) begin
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`endif
                    end else if (op == OP_MUL) begin
                        acc    <= '0;
                        mcand  <= opa;
                        mplier <= opb;
                        cnt    <= '0;
                        state  <= MUL_STEP;
                    end else begin
                        rem   <= '0;
                        quo   <= opa;
                        cnt   <= '0;
                        state <= DIV_CMP;
                    end
                end
                MUL_STEP: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 1'b1;
                    if (mul_done) begin
                        rsp_data  <= acc_nxt;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                DIV_CMP: begin
                    s_q   <= s_now;
                    msb_q <= rem[XLEN-1];
                    lt_q  <= alu_result[0];
                    quo   <= quo << 1;
                    state <= DIV_SUB;
                end
                DIV_SUB: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        rsp_data  <= (op == OP_DIVU) ? quo_nxt : rem_nxt;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= DIV_CMP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq with a behavioural ALU and result/latency/ALU-timeline model.
// Latency: checks each operation's acceptance-to-response cycle count.
// Backpressure: holds rsp_ready low and pokes req_valid while a result is pending.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [2:0]  alu_control;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef ALU_MULDIV_EARLY_EXIT_EN
    localparam int LAT_MUL_B1 = 2;
    localparam int LAT_MUL_B0 = 1;
`else
    localparam int LAT_MUL_B1 = 33;
    localparam int LAT_MUL_B0 = 33;
`endif

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .alu_srca    (alu_srca),
        .alu_srcb    (alu_srcb),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the datapath ALU.
    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_srca + alu_srcb;
            3'b001:  alu_result = alu_srca - alu_srcb;
            3'b010:  alu_result = alu_srca | alu_srcb;
            3'b011:  alu_result = alu_srca & alu_srcb;
            3'b101:  alu_result = {31'd0, alu_srca < alu_srcb};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a * b;
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int mdl_latency(input logic [1:0] op, input logic [31:0] b);
        if (op == 2'b11 || (op != 2'b00 && b == 0)) return 1;
        if (op != 2'b00) return 65;
`ifdef ALU_MULDIV_EARLY_EXIT_EN
        if (b == 0) return 1;
        for (int i = 31; i >= 0; i--) if (b[i]) return i + 2;
`endif
        return 33;
    endfunction

    task automatic chk_idle_alu(input string tag);
        chk({tag, "_srca"}, alu_srca, 32'd0);
        chk({tag, "_srcb"}, alu_srcb, 32'd0);
        chk({tag, "_ctl"}, {29'd0, alu_control}, 32'd0);
    endtask

    // Issue one request, follow it cycle by cycle against the model, then retire it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input bit has_lit, input int lit_lat, input bit hold);
        logic [31:0] exp_r;
        logic [63:0] a64, r64, mask;
        logic [31:0] s_exp;
        int          lat, cyc, w, j, k;
        exp_r = mdl_result(op, a, b);
        lat   = mdl_latency(op, b);
        a64   = {32'd0, a};
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            chk("busy", {31'd0, busy}, 32'd1);
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            if (cyc == 0) begin
                chk_idle_alu("check_alu");
            end else if (op == 2'b00) begin
                j    = cyc - 1;
                mask = (64'd1 << j) - 64'd1;
                chk("mul_ctl", {29'd0, alu_control}, 32'd0);
                chk("mul_srca", alu_srca, 32'(a64 * ({32'd0, b} & mask)));
                chk("mul_srcb", alu_srcb, 32'(a64 << j));
            end else begin
                k     = (cyc - 1) / 2;
                r64   = (k == 0) ? 64'd0 : ((a64 >> (32 - k)) % {32'd0, b});
                s_exp = 32'((r64 << 1) | {63'd0, a[31-k]});
                chk("div_ctl", {29'd0, alu_control}, ((cyc - 1) % 2 == 0) ? 32'd5 : 32'd1);
                chk("div_srca", alu_srca, s_exp);
                chk("div_srcb", alu_srcb, b);
            end
            @(negedge clk);
            cyc++;
        end
        chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        chk("latency", cyc, lat);
        if (lit_lat >= 0) chk("latency_lit", cyc, lit_lat);
        chk("rsp_data", rsp_data, exp_r);
        if (has_lit) chk("rsp_data_lit", rsp_data, lit);
        chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                if (i == 3) begin
                    req_valid = 1'b1;
                    req_op    = 2'b00;
                    req_a     = 32'd2;
                    req_b     = 32'd2;
                end
                if (i == 4) req_valid = 1'b0;
                @(negedge clk);
                chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
                chk("hold_data", rsp_data, exp_r);
                chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk_idle_alu("post_alu");
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk_idle_alu("rst_alu");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'd6, 32'd42, 1'b1, 33, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1, 33, 1'b0);
        run_op(2'b00, 32'd5, 32'd1, 32'd5, 1'b1, LAT_MUL_B1, 1'b0);
        run_op(2'b00, 32'd9, 32'd0, 32'd0, 1'b1, LAT_MUL_B0, 1'b0);
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, -1, 1'b0);
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 1'b1, 65, 1'b0);
        run_op(2'b10, 32'd100, 32'd7, 32'd2, 1'b1, 65, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 1'b1, 65, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 65, 1'b0);
        run_op(2'b01, 32'd1_000_000_007, 32'd3, 32'd0, 1'b0, -1, 1'b0);
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0001_2345, 32'd0, 1'b0, -1, 1'b0);
        run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
        run_op(2'b10, 32'd5, 32'd0, 32'd5, 1'b1, 1, 1'b0);
        run_op(2'b11, 32'd5, 32'd7, 32'd0, 1'b1, 1, 1'b0);

        // Response held under backpressure.
        rsp_ready = 1'b0;
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 1'b1, 65, 1'b1);

        // Reset in the middle of a divide.
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'd100;
        req_b     = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk_idle_alu("mid_rst_alu");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("after_rst_valid", {31'd0, rsp_valid}, 32'd0);
            chk("after_rst_req_ready", {31'd0, req_ready}, 32'd1);
        end
        run_op(2'b00, 32'd3, 32'd4, 32'd12, 1'b1, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
